// File: rtl/ibex_rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package ibex_rf_pkg;

   localparam int RegAddrW = 5;
   localparam int MaxWords = 32;

   typedef logic [RegAddrW-1:0] reg_addr_t;

   function automatic int num_words(input bit rv32e);
      return rv32e ? 16 : 32;
   endfunction

   function automatic logic [5:0] popcount(input logic [MaxWords-1:0] vec);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < MaxWords; i++) begin
         cnt = cnt + 6'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ibex_register_file_mp_if.sv
// Operand read, writeback and scoreboard signals between ID stage and register file.
interface ibex_register_file_mp_if #(
   parameter int DataWidth     = 32,
   parameter int NumReadPorts  = 2,
   parameter int NumWritePorts = 2
);
   import ibex_rf_pkg::*;

   logic                                     dummy_instr_id_i;
   reg_addr_t [NumReadPorts-1:0]             raddr_i;
   logic      [NumReadPorts-1:0][DataWidth-1:0]  rdata_o;
   logic      [NumReadPorts-1:0]             rpend_o;
   reg_addr_t [NumWritePorts-1:0]            waddr_i;
   logic      [NumWritePorts-1:0][DataWidth-1:0] wdata_i;
   logic      [NumWritePorts-1:0]            we_i;
   logic                                     alloc_i;
   reg_addr_t                                alloc_addr_i;
   logic                                     flush_i;
   logic      [5:0]                          pend_cnt_o;

   modport master (
      output dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i,
             alloc_i, alloc_addr_i, flush_i,
      input  rdata_o, rpend_o, pend_cnt_o
   );

   modport slave (
      input  dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i,
             alloc_i, alloc_addr_i, flush_i,
      output rdata_o, rpend_o, pend_cnt_o
   );

endinterface

// File: rtl/ibex_rf_scoreboard.sv
// Per-register pending bits for long-latency producers, with a registered count.
module ibex_rf_scoreboard
   import ibex_rf_pkg::*;
#(
   parameter int NumWords = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                alloc,
   input  reg_addr_t           alloc_addr,
   input  logic                flush,
   input  logic [MaxWords-1:0] clr,
   output logic [MaxWords-1:0] pend,
   output logic [5:0]          pend_cnt
);

   logic [MaxWords-1:0] pend_reg;
   logic [MaxWords-1:0] pend_next;
   logic [5:0]          pend_cnt_reg;

   // Flush beats everything; a new allocation supersedes a retiring writeback.
   always_comb begin
      pend_next = '0;
      if (!flush) begin
         for (int r = 1; r < NumWords; r++) begin
            if (alloc && alloc_addr == RegAddrW'(r)) begin
               pend_next[r] = 1'b1;
            end else if (clr[r]) begin
               pend_next[r] = 1'b0;
            end else begin
               pend_next[r] = pend_reg[r];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_reg     <= '0;
         pend_cnt_reg <= '0;
      end else begin
         pend_reg     <= pend_next;
         pend_cnt_reg <= popcount(pend_next);
      end
   end

   assign pend     = pend_reg;
   assign pend_cnt = pend_cnt_reg;

endmodule

// File: rtl/ibex_register_file_mp.sv
// N-read / M-write flip-flop register file with optional write-through and dummy x0.
module ibex_register_file_mp
   import ibex_rf_pkg::*;
#(
   parameter bit RV32E             = 1'b0,
   parameter int DataWidth         = 32,
   parameter int NumReadPorts      = 2,
   parameter int NumWritePorts     = 2,
   parameter bit WriteThrough      = 1'b0,
   parameter bit DummyInstructions = 1'b0
) (
   input logic clk_i,
   input logic rst_i,
   ibex_register_file_mp_if.slave rf
);

   localparam int NumWords = num_words(RV32E);

   logic [MaxWords-1:0]  wr_hit;
   logic [DataWidth-1:0] wr_data [MaxWords];
   logic [DataWidth-1:0] rf_word [MaxWords];
   logic [MaxWords-1:0]  pend;

   genvar gi;

   // Unimplemented (RV32E upper) words never hit and always read as zero.
   generate
      for (gi = 0; gi < MaxWords; gi++) begin : g_word
         if (gi < NumWords) begin : g_live
            logic                 hit;
            logic [DataWidth-1:0] data;

            // Ascending scan lets the highest-index port win.
            always_comb begin
               hit  = 1'b0;
               data = '0;
               for (int p = 0; p < NumWritePorts; p++) begin
                  if (rf.we_i[p] && rf.waddr_i[p] == RegAddrW'(gi)) begin
                     hit  = 1'b1;
                     data = rf.wdata_i[p];
                  end
               end
            end

            assign wr_hit[gi]  = hit;
            assign wr_data[gi] = data;

            if (gi == 0) begin : g_x0
               if (DummyInstructions) begin : g_dummy
                  logic [DataWidth-1:0] data_reg;
                  always_ff @(posedge clk_i or posedge rst_i) begin
                     if (rst_i) begin
                        data_reg <= '0;
                     end else if (hit && rf.dummy_instr_id_i) begin
                        data_reg <= data;
                     end
                  end
                  assign rf_word[gi] = rf.dummy_instr_id_i ? data_reg : '0;
               end else begin : g_zero
                  assign rf_word[gi] = '0;
               end
            end else begin : g_reg
               logic [DataWidth-1:0] data_reg;
               always_ff @(posedge clk_i or posedge rst_i) begin
                  if (rst_i) begin
                     data_reg <= '0;
                  end else if (hit) begin
                     data_reg <= data;
                  end
               end
               assign rf_word[gi] = data_reg;
            end
         end else begin : g_absent
            assign wr_hit[gi]  = 1'b0;
            assign wr_data[gi] = '0;
            assign rf_word[gi] = '0;
         end
      end
   endgenerate

   ibex_rf_scoreboard #(
      .NumWords (NumWords)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .alloc      (rf.alloc_i),
      .alloc_addr (rf.alloc_addr_i),
      .flush      (rf.flush_i),
      .clr        (wr_hit),
      .pend       (pend),
      .pend_cnt   (rf.pend_cnt_o)
   );

   generate
      for (gi = 0; gi < NumReadPorts; gi++) begin : g_read
         reg_addr_t            addr;
         logic [DataWidth-1:0] rdata;
         logic                 rpend;

         // Bypass never applies to x0, so a dummy write is not visible early.
         always_comb begin
            addr  = rf.raddr_i[gi];
            rdata = rf_word[addr];
            rpend = pend[addr];
            if (WriteThrough && addr != '0 && wr_hit[addr]) begin
               rdata = wr_data[addr];
               if (!(rf.alloc_i && rf.alloc_addr_i == addr)) begin
                  rpend = 1'b0;
               end
            end
         end

         assign rf.rdata_o[gi] = rdata;
         assign rf.rpend_o[gi] = rpend;
      end
   endgenerate

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed checks on two configurations: plain RV32I, and RV32E with write-through and dummy x0.
module tb_ibex_register_file_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ibex_register_file_mp_if #(.DataWidth(32), .NumReadPorts(2), .NumWritePorts(2)) ifa ();
   ibex_register_file_mp_if #(.DataWidth(32), .NumReadPorts(2), .NumWritePorts(2)) ifb ();

   ibex_register_file_mp #(
      .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
      .WriteThrough(1'b0), .DummyInstructions(1'b0)
   ) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .rf    (ifa)
   );

   ibex_register_file_mp #(
      .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
      .WriteThrough(1'b1), .DummyInstructions(1'b1)
   ) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .rf    (ifb)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic idle();
      ifa.we_i = '0; ifa.alloc_i = 1'b0; ifa.flush_i = 1'b0; ifa.dummy_instr_id_i = 1'b0;
      ifb.we_i = '0; ifb.alloc_i = 1'b0; ifb.flush_i = 1'b0; ifb.dummy_instr_id_i = 1'b0;
      ifa.alloc_addr_i = '0; ifb.alloc_addr_i = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wr(input bit on_a, input bit on_b, input int p,
                     input logic [4:0] a, input logic [31:0] d);
      if (on_a) begin
         ifa.we_i[p] = 1'b1; ifa.waddr_i[p] = a; ifa.wdata_i[p] = d;
      end
      if (on_b) begin
         ifb.we_i[p] = 1'b1; ifb.waddr_i[p] = a; ifb.wdata_i[p] = d;
      end
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      ifa.raddr_i[k] = a;
      ifb.raddr_i[k] = a;
   endtask

   task automatic alloc(input bit on_a, input bit on_b, input logic [4:0] a);
      if (on_a) begin
         ifa.alloc_i = 1'b1; ifa.alloc_addr_i = a;
      end
      if (on_b) begin
         ifb.alloc_i = 1'b1; ifb.alloc_addr_i = a;
      end
   endtask

   initial begin
      idle();
      ifa.waddr_i = '0; ifa.wdata_i = '0; ifa.raddr_i = '0;
      ifb.waddr_i = '0; ifb.wdata_i = '0; ifb.raddr_i = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      settle();

      // Reset state on every readable address
      for (int r = 1; r < 32; r++) begin
         rd(0, 5'(r)); rd(1, 5'(r));
         settle();
         check($sformatf("rst_a_rdata0_x%0d", r), 64'(ifa.rdata_o[0]), 64'h0);
         check($sformatf("rst_a_rdata1_x%0d", r), 64'(ifa.rdata_o[1]), 64'h0);
         check($sformatf("rst_a_rpend_x%0d", r), 64'(ifa.rpend_o), 64'h0);
      end
      check("rst_a_cnt", 64'(ifa.pend_cnt_o), 64'h0);
      check("rst_b_cnt", 64'(ifb.pend_cnt_o), 64'h0);

      // Asynchronous reset clears a stored value at once and discards a pending write
      wr(1, 0, 0, 5'd5, 32'hA5A5_A5A5);
      tick();
      rd(0, 5'd5);
      settle();
      check("x5_written", 64'(ifa.rdata_o[0]), 64'hA5A5_A5A5);
      wr(1, 0, 0, 5'd5, 32'h1212_1212);
      rst = 1'b1;
      settle();
      check("x5_async_rst", 64'(ifa.rdata_o[0]), 64'h0);
      tick();
      rst = 1'b0;
      settle();
      check("x5_rst_write_dropped", 64'(ifa.rdata_o[0]), 64'h0);

      // Two ports to x7: higher index wins
      wr(1, 1, 0, 5'd7, 32'h1111_1111);
      wr(1, 1, 1, 5'd7, 32'h2222_2222);
      rd(1, 5'd7);
      settle();
      check("x7_a_before_edge", 64'(ifa.rdata_o[1]), 64'h0);
      check("x7_b_bypass_prio", 64'(ifb.rdata_o[1]), 64'h2222_2222);
      tick();
      settle();
      check("x7_a_prio", 64'(ifa.rdata_o[1]), 64'h2222_2222);
      check("x7_b_prio", 64'(ifb.rdata_o[1]), 64'h2222_2222);

      // x0 write discarded
      wr(1, 1, 0, 5'd0, 32'hFFFF_FFFF);
      rd(0, 5'd0);
      settle();
      check("x0_b_no_bypass", 64'(ifb.rdata_o[0]), 64'h0);
      tick();
      settle();
      check("x0_a_zero", 64'(ifa.rdata_o[0]), 64'h0);
      check("x0_b_zero", 64'(ifb.rdata_o[0]), 64'h0);

      // Write-through vs. registered read on x3
      wr(1, 1, 0, 5'd3, 32'h1234_5678);
      tick();
      wr(1, 1, 0, 5'd3, 32'hDEAD_BEEF);
      rd(1, 5'd3);
      settle();
      check("x3_a_old_value", 64'(ifa.rdata_o[1]), 64'h1234_5678);
      check("x3_b_write_through", 64'(ifb.rdata_o[1]), 64'hDEAD_BEEF);
      tick();
      settle();
      check("x3_a_new_value", 64'(ifa.rdata_o[1]), 64'hDEAD_BEEF);
      check("x3_b_new_value", 64'(ifb.rdata_o[1]), 64'hDEAD_BEEF);

      // Scoreboard on x9
      alloc(1, 1, 5'd9);
      rd(0, 5'd9);
      settle();
      check("x9_pend_not_yet", 64'(ifa.rpend_o[0]), 64'h0);
      tick();
      settle();
      check("x9_a_pend", 64'(ifa.rpend_o[0]), 64'h1);
      check("x9_a_cnt1", 64'(ifa.pend_cnt_o), 64'h1);
      check("x9_b_pend", 64'(ifb.rpend_o[0]), 64'h1);
      check("x9_b_cnt1", 64'(ifb.pend_cnt_o), 64'h1);

      alloc(1, 1, 5'd9);
      wr(1, 1, 0, 5'd9, 32'h0000_0099);
      settle();
      check("x9_b_alloc_keeps_rpend", 64'(ifb.rpend_o[0]), 64'h1);
      tick();
      settle();
      check("x9_a_set_wins", 64'(ifa.rpend_o[0]), 64'h1);
      check("x9_a_cnt_still1", 64'(ifa.pend_cnt_o), 64'h1);
      check("x9_b_cnt_still1", 64'(ifb.pend_cnt_o), 64'h1);

      wr(1, 1, 1, 5'd9, 32'h0000_0077);
      settle();
      check("x9_a_rpend_until_edge", 64'(ifa.rpend_o[0]), 64'h1);
      check("x9_b_rpend_forced0", 64'(ifb.rpend_o[0]), 64'h0);
      check("x9_b_rdata_bypass", 64'(ifb.rdata_o[0]), 64'h77);
      tick();
      settle();
      check("x9_a_cleared", 64'(ifa.rpend_o[0]), 64'h0);
      check("x9_a_cnt0", 64'(ifa.pend_cnt_o), 64'h0);
      check("x9_b_cnt0", 64'(ifb.pend_cnt_o), 64'h0);

      // Successive allocations then flush beating an alloc
      alloc(1, 0, 5'd4); tick(); settle();
      check("cnt_after_x4", 64'(ifa.pend_cnt_o), 64'h1);
      alloc(1, 0, 5'd5); tick(); settle();
      check("cnt_after_x5", 64'(ifa.pend_cnt_o), 64'h2);
      alloc(1, 0, 5'd6); tick(); settle();
      check("cnt_after_x6", 64'(ifa.pend_cnt_o), 64'h3);
      rd(0, 5'd4); rd(1, 5'd6);
      settle();
      check("x4_pend", 64'(ifa.rpend_o), 64'h3);
      ifa.flush_i = 1'b1;
      alloc(1, 0, 5'd8);
      tick();
      settle();
      check("flush_cnt0", 64'(ifa.pend_cnt_o), 64'h0);
      check("flush_x4_x6", 64'(ifa.rpend_o), 64'h0);
      rd(0, 5'd8);
      settle();
      check("flush_beats_alloc_x8", 64'(ifa.rpend_o[0]), 64'h0);

      // RV32E: upper addresses dropped
      wr(0, 1, 0, 5'd20, 32'hCAFE_F00D);
      rd(0, 5'd20);
      settle();
      check("x20_b_no_bypass", 64'(ifb.rdata_o[0]), 64'h0);
      tick();
      settle();
      check("x20_b_dropped", 64'(ifb.rdata_o[0]), 64'h0);
      alloc(0, 1, 5'd20);
      tick();
      settle();
      check("x20_b_alloc_ignored", 64'(ifb.pend_cnt_o), 64'h0);
      check("x20_b_rpend0", 64'(ifb.rpend_o[0]), 64'h0);
      alloc(0, 1, 5'd0);
      tick();
      settle();
      check("x0_b_alloc_ignored", 64'(ifb.pend_cnt_o), 64'h0);

      // Hidden dummy x0
      ifb.dummy_instr_id_i = 1'b1;
      wr(0, 1, 0, 5'd0, 32'h0000_0005);
      tick();
      rd(0, 5'd0);
      ifb.dummy_instr_id_i = 1'b1;
      ifa.dummy_instr_id_i = 1'b1;
      settle();
      check("dummy_b_read5", 64'(ifb.rdata_o[0]), 64'h5);
      check("dummy_a_x0_zero", 64'(ifa.rdata_o[0]), 64'h0);
      ifb.dummy_instr_id_i = 1'b0;
      settle();
      check("dummy_b_hidden", 64'(ifb.rdata_o[0]), 64'h0);
      ifb.dummy_instr_id_i = 1'b1;
      wr(0, 1, 0, 5'd0, 32'h0000_000A);
      wr(0, 1, 1, 5'd0, 32'h0000_000B);
      tick();
      wr(0, 1, 0, 5'd0, 32'h0000_0007);
      tick();
      ifb.dummy_instr_id_i = 1'b1;
      settle();
      check("dummy_b_prio_and_nondummy_drop", 64'(ifb.rdata_o[0]), 64'hB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
